rx_sampler: RTL and testbench
=============================

RX_SAMPLER -- requirements
Module: rx_sampler

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (8): data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16: baud_tick pulses per bit period; even, >= 4.
REQ-003 rx_clk  in  1  single clock; all state on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 baud_tick  in  1  one-cycle enable at OVERSAMPLE x baud rate.
REQ-006 rx_in  in  1  raw serial line, asynchronous, idle high.
REQ-007 start_bit_detected  out  1  one-cycle pulse, start bit validated at mid-bit.
REQ-008 bit_valid  out  1  one-cycle pulse per sampled data, parity and stop bit.
REQ-009 bit_value  out  1  sampled bit; meaningful only when bit_valid=1.
REQ-010 framing_error  out  1  one-cycle pulse when stop bit sampled 0.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 rx_in SHALL pass through a two-flop synchronizer every rx_clk; result rx_s.
REQ-013 line_prev SHALL load rx_s on each baud_tick only.
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP; counters tick_cnt (clog2(OVERSAMPLE) bits) and bit_cnt (clog2(DATA_WIDTH+1) bits).
REQ-015 IDLE: on baud_tick with line_prev=1 and rx_s=0 -> START, tick_cnt<=0; otherwise remain.
REQ-016 START: on each baud_tick, if tick_cnt==OVERSAMPLE/2-1 sample; sample 0 -> pulse start_bit_detected, DATA, tick_cnt<=0, bit_cnt<=0; sample 1 -> IDLE (glitch reject), no pulse; else tick_cnt+1.
REQ-017 DATA/PARITY/STOP: on each baud_tick, if tick_cnt==OVERSAMPLE-1 sample, pulse bit_valid with bit_value, tick_cnt<=0; else tick_cnt+1.
REQ-018 DATA SHALL advance bit_cnt per sample and go to PARITY after sample DATA_WIDTH; bits delivered LSB first in line order.
REQ-019 PARITY -> STOP after one sample; no parity evaluation in this block.
REQ-020 STOP sample -> IDLE; sample 0 additionally pulses framing_error in same cycle as bit_valid.
REQ-021 All outputs SHALL be registered; pulses assert in the rx_clk cycle after the sampling baud_tick and last exactly one cycle.
REQ-022 No baud_tick -> state, counters and outputs (pulses deasserted) SHALL hold.
REQ-023 Falling edge in same baud_tick as STOP-to-IDLE transition SHALL be ignored; next frame needs line_prev=1 first.

Reset
REQ-024 resetn=0 SHALL immediately force IDLE, tick_cnt=0, bit_cnt=0, all outputs 0, synchronizer flops and line_prev to 1.
REQ-025 Reset mid-frame SHALL abandon the frame with no pulses; next valid start bit after release SHALL decode normally.

Configuration
REQ-026 Macro RX_MAJORITY_VOTE_EN defined: sample value SHALL be the 2-of-3 majority of rx_s at the sampling baud_tick and the two preceding baud_ticks (3-entry shift register, reset to 111).
REQ-027 Macro undefined: sample value SHALL be rx_s at the sampling baud_tick only; vote register absent.

Verification
REQ-028 Frame 0xA5, even parity 0, stop 1, OVERSAMPLE=16 -> one start_bit_detected, 10 bit_valid pulses values 1,0,1,0,0,1,0,1,0,1, 16 ticks apart, no framing_error, busy low after.
REQ-029 rx_in low for 4 ticks then high -> no start_bit_detected, no bit_valid, return to IDLE at tick 8.
REQ-030 Frame 0x3C with stop bit 0 -> framing_error pulse coincident with 10th bit_valid, bit_value 0.
REQ-031 resetn low after 3rd data bit -> outputs 0 immediately, no further pulses; following frame 0x81 decodes 1,0,0,0,0,0,0,1.
REQ-032 One-tick high glitch at mid-sample of data bit 0 (value 0) -> bit_value 0 with RX_MAJORITY_VOTE_EN, 1 without.
REQ-033 Two back-to-back frames 0x55, 0xAA, no idle gap -> 2 start pulses, 20 bit_valid pulses, correct values.

Source files
------------

// File: rtl/rx_sampler_if.sv
// +----------------------------------------------------------------------------+
// | Module   : rx_sampler_if                                                   |
// | Brief    : Baud-tick/serial-line inputs and sampled-bit outputs of         |
// |            rx_sampler.                                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rx_sampler_if;
  logic baud_tick;
  logic rx_in;
  logic start_bit_detected;
  logic bit_valid;
  logic bit_value;
  logic framing_error;
  logic busy;

  modport master (
    output baud_tick, rx_in,
    input  start_bit_detected, bit_valid, bit_value, framing_error, busy
  );

  modport slave (
    input  baud_tick, rx_in,
    output start_bit_detected, bit_valid, bit_value, framing_error, busy
  );
endinterface

`default_nettype wire

// File: rtl/rx_sampler.sv
// +----------------------------------------------------------------------------+
// | Module   : rx_sampler                                                      |
// | Brief    : Oversampling UART bit sampler (start/data/parity/stop).         |
// |            Optional macro RX_MAJORITY_VOTE_EN: 2-of-3 vote on samples.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module rx_sampler #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int OVERSAMPLE = 16
) (
  input  wire        rx_clk,
  input  wire        resetn,
  rx_sampler_if.slave rx
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [TICK_W-1:0] c_mid_tick  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] c_last_tick = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  c_last_bit  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t             r_state;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [1:0]         r_sync;
  logic               r_line_prev;
  logic               r_start;
  logic               r_bit_valid;
  logic               r_bit_value;
  logic               r_framing_error;
  logic               r_busy;
  logic               w_rx_s;
  logic               w_sample;

  always_ff @(posedge rx_clk or negedge resetn) begin
    if (!resetn) begin
      r_sync      <= 2'b11;
      r_line_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rx.rx_in};
      if (rx.baud_tick) begin
        r_line_prev <= w_rx_s;
      end
    end
  end

  assign w_rx_s = r_sync[1];

`ifdef RX_MAJORITY_VOTE_EN
  // Two stored ticks plus the live rx_s form the three-entry vote window.
  logic [1:0] r_vote_hist;

  always_ff @(posedge rx_clk or negedge resetn) begin
    if (!resetn) begin
      r_vote_hist <= 2'b11;
    end else if (rx.baud_tick) begin
      r_vote_hist <= {r_vote_hist[0], w_rx_s};
    end
  end

  assign w_sample = (r_vote_hist[1] & r_vote_hist[0]) |
                    (r_vote_hist[1] & w_rx_s) |
                    (r_vote_hist[0] & w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge rx_clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= ST_IDLE;
      r_tick_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_start         <= 1'b0;
      r_bit_valid     <= 1'b0;
      r_bit_value     <= 1'b0;
      r_framing_error <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_start         <= 1'b0;
      r_bit_valid     <= 1'b0;
      r_framing_error <= 1'b0;
      if (rx.baud_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (r_line_prev && !w_rx_s) begin
              r_state    <= ST_START;
              r_busy     <= 1'b1;
              r_tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (r_tick_cnt == c_mid_tick) begin
              if (!w_sample) begin
                r_start    <= 1'b1;
                r_state    <= ST_DATA;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
          ST_DATA, ST_PARITY, ST_STOP: begin
            if (r_tick_cnt == c_last_tick) begin
              r_bit_valid <= 1'b1;
              r_bit_value <= w_sample;
              r_tick_cnt  <= '0;
              case (r_state)
                ST_DATA: begin
                  r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  if (r_bit_cnt == c_last_bit) begin
                    r_state <= ST_PARITY;
                  end
                end
                ST_PARITY: r_state <= ST_STOP;
                default: begin
                  r_state         <= ST_IDLE;
                  r_busy          <= 1'b0;
                  r_framing_error <= !w_sample;
                end
              endcase
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.start_bit_detected = r_start;
  assign rx.bit_valid          = r_bit_valid;
  assign rx.bit_value          = r_bit_value;
  assign rx.framing_error      = r_framing_error;
  assign rx.busy               = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rx_sampler.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_rx_sampler                                                   |
// | Brief    : Scoreboard bench for rx_sampler (DATA_WIDTH=8, OVERSAMPLE=16).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rx_sampler;

  typedef struct {
    bit is_start;
    bit val;
    bit ferr;
    int tick;
  } ev_t;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  int   tick_num;
  ev_t  exp_q[$];

`ifdef RX_MAJORITY_VOTE_EN
  localparam bit c_vote = 1'b1;
`else
  localparam bit c_vote = 1'b0;
`endif

  rx_sampler_if rx_if ();

  rx_sampler dut (
    .rx_clk (clk),
    .resetn (resetn),
    .rx     (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line value for one baud tick; rx_in settles through the synchronizer first.
  task automatic do_tick(input logic v);
    rx_if.rx_in = v;
    repeat (3) @(negedge clk);
    rx_if.baud_tick = 1'b1;
    @(negedge clk);
    rx_if.baud_tick = 1'b0;
    tick_num++;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b1);
  endtask

  // Drive the first nticks ticks of a frame, optionally inverting one tick,
  // and queue every event whose sample tick falls within the driven span.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input int glitch, input int nticks);
    logic [10:0] bits;
    int          t0;
    int          off;
    logic        v;
    ev_t         e;
    bits = {stop_v, ^d, d, 1'b0};
    t0   = tick_num;
    if (8 < nticks) begin
      e = '{is_start: 1'b1, val: 1'b0, ferr: 1'b0, tick: t0 + 8};
      exp_q.push_back(e);
    end
    for (int k = 0; k < 10; k++) begin
      off = 8 + 16 * (k + 1);
      v   = bits[k+1] ^ ((glitch == off) && !c_vote);
      e   = '{is_start: 1'b0, val: v, ferr: (k == 9) && !v, tick: t0 + off};
      if (off < nticks) exp_q.push_back(e);
    end
    for (int i = 0; i < nticks; i++) begin
      v = bits[i/16];
      if (i == glitch) v = ~v;
      do_tick(v);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_start"}, int'(rx_if.start_bit_detected), 0);
    check({name, "_valid"}, int'(rx_if.bit_valid), 0);
    check({name, "_value"}, int'(rx_if.bit_value), 0);
    check({name, "_ferr"},  int'(rx_if.framing_error), 0);
    check({name, "_busy"},  int'(rx_if.busy), 0);
  endtask

  // Monitor: every output pulse is matched against the head of the queue.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (rx_if.start_bit_detected) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("start_kind", int'(e.is_start), 1);
        check("start_tick", tick_num, e.tick);
      end
    end
    if (rx_if.bit_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("bit_kind", int'(e.is_start), 0);
        check("bit_value", int'(rx_if.bit_value), int'(e.val));
        check("bit_ferr", int'(rx_if.framing_error), int'(e.ferr));
        check("bit_tick", tick_num, e.tick);
      end
    end
    if (rx_if.framing_error && !rx_if.bit_valid) begin
      check("lone_ferr", 1, 0);
    end
  end

  initial begin
    total           = 0;
    bad             = 0;
    tick_num        = 0;
    resetn          = 1'b0;
    rx_if.rx_in     = 1'b1;
    rx_if.baud_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    resetn = 1'b1;
    idle_ticks(4);

    // Nominal frame, then a short low glitch that must be rejected mid-bit.
    send_frame(8'hA5, 1'b1, -1, 176);
    idle_ticks(4);
    check("a5_busy_after", int'(rx_if.busy), 0);

    for (int i = 0; i < 12; i++) begin
      do_tick((i < 4) ? 1'b0 : 1'b1);
      check("glitch_busy", int'(rx_if.busy), (i < 8) ? 1 : 0);
    end
    idle_ticks(4);

    send_frame(8'h3C, 1'b0, -1, 176);
    idle_ticks(4);

    // One-tick high pulse on the mid-sample of data bit 0.
    send_frame(8'h3C, 1'b1, 24, 176);
    idle_ticks(4);

    send_frame(8'h55, 1'b1, -1, 176);
    send_frame(8'hAA, 1'b1, -1, 176);
    idle_ticks(4);
    check("b2b_busy_after", int'(rx_if.busy), 0);

    // Abandon a frame just after its third data bit.
    send_frame(8'hA5, 1'b1, -1, 60);
    check("pre_reset_busy", int'(rx_if.busy), 1);
    rx_if.rx_in = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check_quiet("midreset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check("queue_at_reset", exp_q.size(), 0);
    idle_ticks(8);
    send_frame(8'h81, 1'b1, -1, 176);
    idle_ticks(20);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
